// File: rtl/imm_field_packer.sv
// Two-stage elastic packer: narrows a signed 32-bit operand into the 18-bit immediate
// or 22-bit Md field, flags misfits, counts overflows. Saturating build: IMM_PACK_SATURATE_EN.
module imm_field_packer #(
  parameter int IMM_W = 18,
  parameter int MD_W  = 22,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MD_W-1:0]  out_field,
  output logic             out_ovf,
  output logic             out_mode,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic             s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [MD_W-1:0]  s2_field_q, s2_field_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_mode_q, s2_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s1_ready, in_xfer, s12_xfer, out_xfer;

  assign s1_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_ready;
  assign in_xfer  = in_valid && in_ready;
  assign s12_xfer = s1_valid_q && s1_ready;
  assign out_xfer = s2_valid_q && out_ready;

  // Operand fits W bits iff every bit from 31 down to the field's sign bit agrees.
  logic [32-IMM_W:0] hi_imm;
  logic [32-MD_W:0]  hi_md;
  logic              fits_imm, fits_md, fits, neg;
  logic [MD_W-1:0]   fld_imm, fld_md, fld_ovf;

  assign hi_imm   = s1_data_q[31:IMM_W-1];
  assign hi_md    = s1_data_q[31:MD_W-1];
  assign fits_imm = (&hi_imm) || !(|hi_imm);
  assign fits_md  = (&hi_md) || !(|hi_md);
  assign fits     = s1_mode_q ? fits_md : fits_imm;
  assign neg      = s1_data_q[31];
  assign fld_imm  = {{(MD_W-IMM_W){1'b0}}, s1_data_q[IMM_W-1:0]};
  assign fld_md   = s1_data_q[MD_W-1:0];

`ifdef IMM_PACK_SATURATE_EN
  always_comb begin
    fld_ovf = '0;
    if (s1_mode_q) fld_ovf = {neg, {(MD_W-1){!neg}}};
    else           fld_ovf = {{(MD_W-IMM_W){1'b0}}, neg, {(IMM_W-1){!neg}}};
  end
`else
  assign fld_ovf = s1_mode_q ? fld_md : fld_imm;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_mode_d  = in_mode;
    end else if (s12_xfer) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_field_d = s2_field_q;
    s2_ovf_d   = s2_ovf_q;
    s2_mode_d  = s2_mode_q;
    if (s12_xfer) begin
      s2_valid_d = 1'b1;
      s2_field_d = fits ? (s1_mode_q ? fld_md : fld_imm) : fld_ovf;
      s2_ovf_d   = !fits;
      s2_mode_d  = s1_mode_q;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)                           cnt_d = '0;
    else if (out_xfer && s2_ovf_q && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_field_q <= '0;
      s2_ovf_q   <= 1'b0;
      s2_mode_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_field_q <= s2_field_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_mode_q  <= s2_mode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_field = s2_field_q;
  assign out_ovf   = s2_ovf_q;
  assign out_mode  = s2_mode_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_imm_field_packer.sv
// Scoreboard bench for imm_field_packer: expected results queued at input transfer,
// checked every cycle the output is valid.
module tb_imm_field_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_ovf, out_mode, clr_count;
  logic [21:0] out_field;
  logic [15:0] ovf_count;

  always #5 clk = ~clk;

  imm_field_packer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
    .out_ovf(out_ovf), .out_mode(out_mode), .ovf_count(ovf_count), .clr_count(clr_count)
  );

  typedef struct {
    logic [21:0] field;
    logic        ovf;
    logic        mode;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  logic        xfer_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic m);
    exp_t   e;
    int     w;
    longint v, lo, hi, mask, f;
    w    = m ? 22 : 18;
    v    = longint'($signed(d));
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -(longint'(1) <<< (w - 1));
    mask = (longint'(1) <<< w) - 1;
    e.ovf  = (v < lo) || (v > hi);
    e.mode = m;
    f = v & mask;
`ifdef IMM_PACK_SATURATE_EN
    if (v > hi) f = hi & mask;
    if (v < lo) f = lo & mask;
`endif
    e.field = f[21:0];
    return e;
  endfunction

  // Scoreboard: held outputs must keep matching the head entry every stalled cycle.
  always @(negedge clk) begin
    xfer_ovf = 1'b0;
    if (!reset_n) begin
      exp_cnt = '0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          cur = q[0];
          chk("field", 32'(out_field), 32'(cur.field));
          chk("ovf",   32'(out_ovf),   32'(cur.ovf));
          chk("mode",  32'(out_mode),  32'(cur.mode));
          if (out_ready) begin
            chk("ovf_count", 32'(ovf_count), 32'(exp_cnt));
            xfer_ovf = cur.ovf;
            void'(q.pop_front());
          end
        end
      end
      if (clr_count)                          exp_cnt = '0;
      else if (xfer_ovf && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic send(input logic [31:0] d, input logic m);
    int n = 0;
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_mode = m;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(d, m));
        done = 1;
      end else if (++n > 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0) && (n < 500)) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] t2_data [8] = '{32'hFFFE0000, 32'h00020000, 32'hFFFDFFFF, 32'h00000000,
                               32'h001FFFFF, 32'hFFE00000, 32'h00200000, 32'h80000000};
  logic        t2_mode [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int n;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_field", 32'(out_field), 32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_out_mode",  32'(out_mode),  32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: latency
    send(32'h0001FFFF, 1'b0);
    chk("lat_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_c2", 32'(out_valid), 32'd1);
    drain();

    // 2: bounds, back-to-back
    for (int i = 0; i < 8; i++) send(t2_data[i], t2_mode[i]);
    drain();

    // 3: Md negative overflow, count from zero
    @(posedge clk); #1 clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    send(32'hFFDFFFFF, 1'b1);
    drain();
    chk("t3_ovf_count", 32'(ovf_count), 32'd1);

    // 4: burst with downstream stall
    out_ready = 1'b0;
    send(32'h00000011, 1'b0);
    send(32'hFFFFFF22, 1'b1);
    in_valid = 1'b1; in_data = 32'h00012333; in_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h00012333, 1'b0);
    send(32'h00040000, 1'b0);
    send(32'hFFF00055, 1'b1);
    send(32'h7FFFFFFF, 1'b1);
    drain();

    // 5: saturation and clear priority
    @(posedge clk); #1 clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    for (int i = 0; i < 65535; i++) send(32'h00020000, 1'b0);
    drain();
    chk("sat_reach", 32'(ovf_count), 32'hFFFF);
    send(32'hFFFDFFFF, 1'b0);
    drain();
    chk("sat_hold", 32'(ovf_count), 32'hFFFF);
    out_ready = 1'b0;
    send(32'h00020000, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("clr_setup_valid", 32'(out_valid), 32'd1);
    clr_count = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    chk("clr_priority", 32'(ovf_count), 32'd0);
    drain();

    // 6: reset with two entries in flight
    out_ready = 1'b0;
    send(32'h00000123, 1'b0);
    send(32'h00000456, 1'b1);
    reset_n = 1'b0;
    #1 chk("rst_flight_valid", 32'(out_valid), 32'd0);
    q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
